// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the bit-counter width helper.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must index W bit-cycles; a 1-bit counter still suffices for W=1.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// 1-bit full subtractor cell: d = x - y - bin, bout = borrow out.
// Purely combinational.
module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, diff = a - b, LSB first, one bit per clock.
// Optional feature macro: SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
//
// Handshake: an operation is accepted on any rising edge where start is high
// and busy is low (IDLE or DONE). While busy is high, start is ignored and
// a/b are don't-care. done is a single-cycle pulse during which diff/borrow
// (and ovf) hold the new result; they keep that value until the next result.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         borrow,
`ifdef SERIAL_SUB_OVF_EN
    output logic         ovf,
`endif
    output state_t       state
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t         state_n;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   a_sh;
    logic [W-1:0]   b_sh;
    logic [W-1:0]   diff_sh;
    logic [W-1:0]   diff_sh_n;
    logic           bor;
    logic           d_bit;
    logic           bout_bit;
    logic           accept;
    logic           last_bit;

    assign busy     = (state == ST_SHIFT);
    assign done     = (state == ST_DONE);
    assign accept   = start && !busy;
    assign last_bit = busy && (cnt == LAST);

    full_subtractor u_fsub (
        .x    (a_sh[0]),
        .y    (b_sh[0]),
        .bin  (bor),
        .d    (d_bit),
        .bout (bout_bit)
    );

    // The new difference bit enters at the MSB so that after W shifts the
    // LSB computed first ends up at bit 0.
    generate
        if (W == 1) begin : g_one
            assign diff_sh_n = d_bit;
        end else begin : g_many
            assign diff_sh_n = {d_bit, diff_sh[W-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Next-state logic; DONE re-accepts start directly for back-to-back ops.
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (start) state_n = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST) state_n = ST_DONE;
            ST_DONE:  state_n = start ? ST_SHIFT : ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    // Datapath: operand capture, per-bit shifting, result write on the last bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            bor     <= 1'b0;
            diff    <= '0;
            borrow  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            bor  <= 1'b0;
            cnt  <= '0;
        end else if (busy) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= diff_sh_n;
            bor     <= bout_bit;
            cnt     <= cnt + CW'(1);
            if (last_bit) begin
                diff   <= diff_sh_n;
                borrow <= bout_bit;
`ifdef SERIAL_SUB_OVF_EN
                // On the last bit a_sh[0]/b_sh[0] are the operand sign bits.
                ovf    <= (a_sh[0] ^ b_sh[0]) & (a_sh[0] ^ d_bit);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor: a W=8 instance and a
// W=1 instance. Define SERIAL_SUB_OVF_EN to also exercise the ovf output.
module tb_serial_subtractor;
    import serial_subtractor_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- W=8 instance ----------------
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, borrow;
    logic [7:0] diff;
    state_t     state;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    serial_subtractor #(.W(8)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
`ifdef SERIAL_SUB_OVF_EN
        .ovf    (ovf),
`endif
        .state  (state)
    );

    // ---------------- W=1 instance ----------------
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0;
    logic [0:0] b1 = '0;
    logic       busy1, done1, borrow1;
    logic [0:0] diff1;
    state_t     state1;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf1;
`endif

    serial_subtractor #(.W(1)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .start  (start1),
        .a      (a1),
        .b      (b1),
        .busy   (busy1),
        .done   (done1),
        .diff   (diff1),
        .borrow (borrow1),
`ifdef SERIAL_SUB_OVF_EN
        .ovf    (ovf1),
`endif
        .state  (state1)
    );

    // ---------------- scoreboard ----------------
    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Launch one W=8 op at a negedge and wait for done; latency counted in
    // negedges from the one that raised start.
    task automatic do_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                         input logic [7:0] exp_d, input logic exp_b);
        int         n;
        bit         seen;
        logic [8:0] exp;
        exp_q.push_back({exp_b, exp_d});
        a = op_a;
        b = op_b;
        start = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 1) check({tag, "_busy"}, 32'(busy), 32'd1);
            if (done) seen = 1;
        end
        exp = exp_q.pop_front();
        check({tag, "_lat"}, n, 32'd9);
        check({tag, "_diff"}, 32'(diff), 32'(exp[7:0]));
        check({tag, "_borrow"}, 32'(borrow), 32'(exp[8]));
        check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic do_op1(input string tag, input logic op_a, input logic op_b,
                          input logic exp_d, input logic exp_b);
        int n;
        bit seen;
        a1 = op_a;
        b1 = op_b;
        start1 = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            start1 = 1'b0;
            if (done1) seen = 1;
        end
        check({tag, "_lat"}, n, 32'd2);
        check({tag, "_diff"}, 32'(diff1), 32'(exp_d));
        check({tag, "_borrow"}, 32'(borrow1), 32'(exp_b));
        @(negedge clk);
        check({tag, "_done_pulse"}, 32'(done1), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int d1;
        int d2;
        int done_cnt;
        logic [7:0] ra;
        logic [7:0] rb;

        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_w1_diff", 32'(diff1), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_op("sub_200_55", 8'd200, 8'd55, 8'd145, 1'b0);
        do_op("sub_55_200", 8'd55, 8'd200, 8'h6F, 1'b1);
        do_op("sub_0_1", 8'h00, 8'h01, 8'hFF, 1'b1);
        do_op("sub_a5_a5", 8'hA5, 8'hA5, 8'h00, 1'b0);

        // start pulse 3 cycles into an op must be ignored
        a = 8'd200; b = 8'd55; start = 1'b1; n = 0; d1 = -1;
        while (d1 < 0 && n < 40) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (n == 1) begin a = 8'd3; b = 8'd9; end
            if (n == 3) start = 1'b1;
            if (done) d1 = n;
        end
        start = 1'b0;
        check("ign_lat", d1, 32'd9);
        check("ign_diff", 32'(diff), 32'd145);
        check("ign_borrow", 32'(borrow), 32'd0);
        @(negedge clk);
        check("ign_idle", 32'(state), 32'(ST_IDLE));

        // start held high through DONE: back-to-back ops, period W+1
        a = 8'd200; b = 8'd55; start = 1'b1; n = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin a = 8'h00; b = 8'h01; end
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    check("b2b_diff1", 32'(diff), 32'd145);
                    check("b2b_borrow1", 32'(borrow), 32'd0);
                end else begin
                    d2 = n;
                    check("b2b_diff2", 32'(diff), 32'hFF);
                    check("b2b_borrow2", 32'(borrow), 32'd1);
                end
            end
            if (d1 >= 0 && n == d1 + 1) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_lat1", d1, 32'd9);
        check("b2b_lat2", d2, 32'd18);
        @(negedge clk);
        check("b2b_end_done", 32'(done), 32'd0);
        check("b2b_end_busy", 32'(busy), 32'd0);

        // reset mid-SHIFT aborts the op
        a = 8'd55; b = 8'd200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_diff", 32'(diff), 32'd0);
        check("mid_rst_borrow", 32'(borrow), 32'd0);
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("mid_rst_no_done", done_cnt, 32'd0);
        do_op("after_rst", 8'd10, 8'd3, 8'd7, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        do_op("ovf_80_01", 8'h80, 8'h01, 8'h7F, 1'b0);
        check("ovf_80_01_ovf", 32'(ovf), 32'd1);
        do_op("ovf_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        check("ovf_05_03_ovf", 32'(ovf), 32'd0);
`endif

        // random operands against the reference a - b
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            do_op("rand", ra, rb, ra - rb, (ra < rb) ? 1'b1 : 1'b0);
        end

        // W=1 build: all four operand combinations
        do_op1("w1_0_0", 1'b0, 1'b0, 1'b0, 1'b0);
        do_op1("w1_0_1", 1'b0, 1'b1, 1'b1, 1'b1);
        do_op1("w1_1_0", 1'b1, 1'b0, 1'b1, 1'b0);
        do_op1("w1_1_1", 1'b1, 1'b1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
